// File: rtl/coco_pkg.sv
// Shared types for the CoCo system-RAM arbiter.
// FSM states, slot grant codes and the default DMA starvation limit.
package coco_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VDG_A,
    VDG_D,
    CPU_A,
    CPU_D,
    CPU_W,
    DMA_A,
    DMA_D
  } arb_state_t;

  typedef enum logic [2:0] {
    SLOT_NONE,
    SLOT_VDG,
    SLOT_CPU_RD,
    SLOT_CPU_WR,
    SLOT_DMA
  } slot_t;

  localparam int STARVE_DEF = 16;

endpackage

// File: rtl/ram_slot_edge.sv
// SAM E/Q sampler for the RAM arbiter.
// Registers E/Q on clk_ena and flags the edges seen on that tick.
module ram_slot_edge (
  input  logic clk,
  input  logic reset,
  input  logic clk_ena,
  input  logic e,
  input  logic q,
  output logic q_rise,
  output logic e_rise,
  output logic e_fall
);

  logic e_d;
  logic q_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_d <= 1'b0;
      q_d <= 1'b0;
    end else if (clk_ena) begin
      e_d <= e;
      q_d <= q;
    end
  end

  assign q_rise = clk_ena & q & ~q_d;
  assign e_rise = clk_ena & e & ~e_d;
  assign e_fall = clk_ena & ~e & e_d;

endmodule

// File: rtl/coco_ram_arbiter.sv
// Time-slot arbiter for the shared 64K system RAM port.
// Serves VDG fetches, CPU reads/writes and loader DMA writes.
module coco_ram_arbiter
  import coco_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = STARVE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ena,
  input  logic              e,
  input  logic              q,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_rw,
  input  logic              cpu_ram_cs,
  output logic [7:0]        cpu_din,
  input  logic [ADDR_W-1:0] vdg_addr,
  output logic [7:0]        vdg_data,
  output logic              vdg_valid,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_data,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_en,
  input  logic [7:0]        ram_rdata,
  output logic              busy
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_t state, state_nx;
  slot_t      slot;

  logic q_rise, e_rise, e_fall;
  logic vdg_pend, cpu_rd_pend, cpu_wr_pend;
  logic [ADDR_W-1:0] vdg_lat, rd_addr, wr_addr;
  logic [7:0]        wr_data;
  logic [CW-1:0]     starve_cnt;
  logic              starve_hit;

  ram_slot_edge u_edge (
    .clk     (clk),
    .reset   (reset),
    .clk_ena (clk_ena),
    .e       (e),
    .q       (q),
    .q_rise  (q_rise),
    .e_rise  (e_rise),
    .e_fall  (e_fall)
  );

  assign busy       = (state != IDLE);
  assign starve_hit = dma_req &&
                      (starve_cnt >= CW'(STARVE_MAX));

  // Writes go first so the latched E-fall data is never overwritten.
  always_comb begin
    slot = SLOT_NONE;
    if (clk_ena && state == IDLE) begin
      if (cpu_wr_pend)      slot = SLOT_CPU_WR;
      else if (vdg_pend)    slot = SLOT_VDG;
      else if (starve_hit)  slot = SLOT_DMA;
      else if (cpu_rd_pend) slot = SLOT_CPU_RD;
      else if (dma_req)     slot = SLOT_DMA;
    end
  end

  always_comb begin
    state_nx = state;
    if (clk_ena) begin
      unique case (state)
        IDLE: begin
          unique case (slot)
            SLOT_VDG:    state_nx = VDG_A;
            SLOT_CPU_RD: state_nx = CPU_A;
            SLOT_CPU_WR: state_nx = CPU_W;
            SLOT_DMA:    state_nx = DMA_A;
            default:     state_nx = IDLE;
          endcase
        end
        VDG_A:   state_nx = VDG_D;
        CPU_A:   state_nx = CPU_D;
        DMA_A:   state_nx = DMA_D;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vdg_pend    <= 1'b0;
      cpu_rd_pend <= 1'b0;
      cpu_wr_pend <= 1'b0;
      vdg_lat     <= '0;
      rd_addr     <= '0;
      wr_addr     <= '0;
      wr_data     <= 8'h00;
      starve_cnt  <= '0;
    end else if (clk_ena) begin
      // A second edge on an already-set pend is dropped.
      if (q_rise && !vdg_pend) begin
        vdg_pend <= 1'b1;
        vdg_lat  <= vdg_addr;
      end else if (slot == SLOT_VDG) begin
        vdg_pend <= 1'b0;
      end
      if (e_rise && cpu_ram_cs && cpu_rw &&
          !cpu_rd_pend) begin
        cpu_rd_pend <= 1'b1;
        rd_addr     <= cpu_addr;
      end else if (slot == SLOT_CPU_RD) begin
        cpu_rd_pend <= 1'b0;
      end
      if (e_fall && cpu_ram_cs && !cpu_rw &&
          !cpu_wr_pend) begin
        cpu_wr_pend <= 1'b1;
        wr_addr     <= cpu_addr;
        wr_data     <= cpu_dout;
      end else if (slot == SLOT_CPU_WR) begin
        cpu_wr_pend <= 1'b0;
      end
      if (!dma_req || slot == SLOT_DMA ||
          state == DMA_A || state == DMA_D)
        starve_cnt <= '0;
      else if (starve_cnt < CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_addr  <= '0;
      ram_wdata <= 8'h00;
      ram_we    <= 1'b0;
      ram_en    <= 1'b0;
      cpu_din   <= 8'h00;
      vdg_data  <= 8'h00;
      vdg_valid <= 1'b0;
      dma_ack   <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      vdg_valid <= 1'b0;
      dma_ack   <= 1'b0;
      if (clk_ena) begin
        ram_en <= (state_nx != IDLE);
        unique case (slot)
          SLOT_VDG:    ram_addr <= vdg_lat;
          SLOT_CPU_RD: ram_addr <= rd_addr;
          SLOT_CPU_WR: begin
            ram_addr  <= wr_addr;
            ram_wdata <= wr_data;
            ram_we    <= 1'b1;
          end
          SLOT_DMA: begin
            ram_addr  <= dma_addr;
            ram_wdata <= dma_data;
            ram_we    <= 1'b1;
          end
          default: ;
        endcase
        if (state == VDG_D) begin
          vdg_data  <= ram_rdata;
          vdg_valid <= 1'b1;
        end
        if (state == CPU_D) cpu_din <= ram_rdata;
        if (state == DMA_A) dma_ack <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coco_ram_arbiter.sv
// Directed bench for coco_ram_arbiter.
// Uses a registered-read dpram model behind the arbiter.
module tb_coco_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_ena;
  logic        e, q;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw;
  logic        cpu_ram_cs;
  logic [7:0]  cpu_din;
  logic [15:0] vdg_addr;
  logic [7:0]  vdg_data;
  logic        vdg_valid;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_ack;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_en;
  logic [7:0]  ram_rdata;
  logic        busy;

  coco_ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .clk_ena    (clk_ena),
    .e          (e),
    .q          (q),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_rw     (cpu_rw),
    .cpu_ram_cs (cpu_ram_cs),
    .cpu_din    (cpu_din),
    .vdg_addr   (vdg_addr),
    .vdg_data   (vdg_data),
    .vdg_valid  (vdg_valid),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_data   (dma_data),
    .dma_ack    (dma_ack),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_en     (ram_en),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int          we_cnt = 0;
  int          ack_cnt = 0;
  int          vv_cnt = 0;
  logic [15:0] last_wa = '0;
  logic [7:0]  last_wd = '0;

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      last_wa <= ram_addr;
      last_wd <= ram_wdata;
    end
    if (dma_ack)   ack_cnt <= ack_cnt + 1;
    if (vdg_valid) vv_cnt  <= vv_cnt + 1;
  end

  int   n_chk = 0;
  int   n_pass = 0;
  int   phase = 0;
  int   qr_cnt = 0;
  logic q_last = 1'b0;
  logic vdg_run = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    if (vdg_run) begin
      phase++;
      q = phase[2];
    end
    if (q && !q_last) qr_cnt++;
    q_last = q;
    @(negedge clk);
    clk_ena = 1'b1;
    @(negedge clk);
    clk_ena = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_read(input logic [15:0] a);
    e = 1'b0;
    tick();
    cpu_addr   = a;
    cpu_rw     = 1'b1;
    cpu_ram_cs = 1'b1;
    e          = 1'b1;
    repeat (4) tick();
    cpu_ram_cs = 1'b0;
  endtask

  int w0, a0, v0, q0, it, bad, tmo;
  logic got;

  initial begin
    reset = 1'b0; clk_ena = 1'b0;
    e = 1'b0; q = 1'b0;
    cpu_addr = '0; cpu_dout = '0;
    cpu_rw = 1'b1; cpu_ram_cs = 1'b0;
    vdg_addr = '0; dma_req = 1'b0;
    dma_addr = '0; dma_data = '0;
    mem[16'h1234] = 8'hA5;
    mem[16'h0600] = 8'h3C;
    mem[16'h8000] = 8'hC3;
    repeat (3) @(negedge clk);
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_en", 32'(ram_en), 0);
    chk("rst_cpu_din", 32'(cpu_din), 0);
    chk("rst_vdg_data", 32'(vdg_data), 0);
    chk("rst_pulses", 32'(ack_cnt + vv_cnt), 0);
    reset = 1'b1;
    tick();

    // CPU read: addr one tick after grant, data two ticks after that
    cpu_addr = 16'h1234; cpu_rw = 1'b1;
    cpu_ram_cs = 1'b1; e = 1'b1;
    tick();
    tick();
    chk("rd_addr", 32'(ram_addr), 32'h1234);
    chk("rd_busy", 32'(busy), 1);
    tick();
    tick();
    chk("rd_data", 32'(cpu_din), 32'hA5);

    // CPU write latched at E fall
    w0 = we_cnt;
    cpu_addr = 16'h0400; cpu_dout = 8'h5A;
    cpu_rw = 1'b0;
    tick();
    e = 1'b0;
    repeat (4) tick();
    chk("wr_pulses", 32'(we_cnt - w0), 1);
    chk("wr_addr", 32'(last_wa), 32'h0400);
    chk("wr_data", 32'(last_wd), 32'h5A);
    cpu_read(16'h0400);
    chk("wr_readback", 32'(cpu_din), 32'h5A);

    // Simultaneous Q and E rise: VDG first, then CPU
    e = 1'b0; q = 1'b0;
    tick();
    v0 = vv_cnt;
    vdg_addr = 16'h0600; cpu_addr = 16'h8000;
    cpu_rw = 1'b1; cpu_ram_cs = 1'b1;
    e = 1'b1; q = 1'b1;
    tick();
    tick();
    chk("both_vdg_addr", 32'(ram_addr), 32'h0600);
    tick();
    tick();
    chk("both_vdg_data", 32'(vdg_data), 32'h3C);
    chk("both_vdg_valid", 32'(vv_cnt - v0), 1);
    tick();
    chk("both_cpu_addr", 32'(ram_addr), 32'h8000);
    tick();
    tick();
    chk("both_cpu_data", 32'(cpu_din), 32'hC3);

    // DMA against a CPU read every other tick
    e = 1'b0; q = 1'b0;
    tick();
    cpu_addr = 16'h1234; e = 1'b1;
    tick();
    a0 = ack_cnt; w0 = we_cnt;
    dma_req = 1'b1; dma_addr = 16'h2000;
    dma_data = 8'h77;
    got = 1'b0; it = 0;
    for (int i = 0; i < 16 + 4 && !got; i++) begin
      e = ~e;
      tick();
      if (ack_cnt != a0) begin
        got = 1'b1;
        it  = i + 1;
      end
    end
    chk("starve_ack", 32'(got), 1);
    chk("starve_late", 32'(it >= 16), 1);
    chk("starve_wr", {last_wa, 8'h00, last_wd},
        32'h2000_0077);
    dma_req = 1'b0; cpu_ram_cs = 1'b0;
    repeat (4) tick();
    chk("starve_cnt0", 32'(dut.starve_cnt), 0);
    chk("starve_idle", 32'(busy), 0);

    // Loader fills 0x0E00..0x0EFF while VDG fetches
    e = 1'b0; q = 1'b0;
    tick();
    w0 = we_cnt; v0 = vv_cnt; q0 = qr_cnt;
    vdg_addr = 16'h0600; phase = 0;
    vdg_run = 1'b1; tmo = 0;
    for (int i = 0; i < 256; i++) begin
      dma_addr = 16'h0E00 + 16'(i);
      dma_data = 8'(i) ^ 8'h5A;
      dma_req  = 1'b1;
      a0  = ack_cnt;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        tick();
        if (ack_cnt != a0) got = 1'b1;
      end
      if (!got) tmo++;
    end
    dma_req = 1'b0; vdg_run = 1'b0;
    repeat (8) tick();
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[16'h0E00 + 16'(i)] !== (8'(i) ^ 8'h5A))
        bad++;
    chk("ld_timeouts", 32'(tmo), 0);
    chk("ld_writes", 32'(we_cnt - w0), 256);
    chk("ld_bytes_bad", 32'(bad), 0);
    chk("ld_vdg_fetches", 32'(vv_cnt - v0),
        32'(qr_cnt - q0));
    chk("ld_vdg_data", 32'(vdg_data), 32'h3C);
    q = 1'b0;
    cpu_read(16'h0E00);
    chk("ld_first", 32'(cpu_din), 32'h5A);
    cpu_read(16'h0EFF);
    chk("ld_last", 32'(cpu_din), 32'hA5);

    // Reset lands while the DMA write slot is active
    e = 1'b0; q = 1'b0;
    tick();
    a0 = ack_cnt; v0 = vv_cnt;
    dma_req = 1'b1; dma_addr = 16'h3000;
    dma_data = 8'hEE; q = 1'b1;
    @(negedge clk);
    clk_ena = 1'b1;
    @(negedge clk);
    clk_ena = 1'b0;
    chk("mid_we_set", 32'(ram_we), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_we_clr", 32'(ram_we), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_addr", 32'(ram_addr), 0);
    chk("mid_en", 32'(ram_en), 0);
    chk("mid_din", {cpu_din, vdg_data}, 0);
    repeat (2) tick();
    q = 1'b0; dma_req = 1'b0;
    reset = 1'b1;
    repeat (6) tick();
    chk("mid_no_ack", 32'(ack_cnt - a0), 0);
    chk("mid_no_vdg", 32'(vv_cnt - v0), 0);
    chk("mid_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
